// File: rtl/window_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : window_fetcher                                               |
// | Description : 3x3 neighbourhood fetcher. Reads an IMG_W x IMG_H raster     |
// |               image from a single-port RAM, one tap per cycle, and hands   |
// |               each assembled window to the filter core over valid/ready.   |
// | Ports       : clk, rst (async, active-low)                                 |
// |               start / busy / done      - frame handshake                   |
// |               mem_en / mem_addr / mem_dout - RAM read port                 |
// |               win_data / win_valid / win_ready - window stream             |
// |               win_row / win_col        - centre of the current window      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module window_fetcher #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1,
  parameter int BORDER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_dout,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [15:0]        win_row,
  output logic [15:0]        win_col
);

  // Centre scan range: interior only, or the full frame when borders are synthesised.
  localparam logic [15:0] c_R_FIRST = (BORDER == 0) ? 16'd1 : 16'd0;
  localparam logic [15:0] c_C_FIRST = (BORDER == 0) ? 16'd1 : 16'd0;
  localparam logic [15:0] c_R_LAST  = (BORDER == 0) ? 16'(IMG_H - 2) : 16'(IMG_H - 1);
  localparam logic [15:0] c_C_LAST  = (BORDER == 0) ? 16'(IMG_W - 2) : 16'(IMG_W - 1);
  localparam logic [15:0] c_H_MAX   = 16'(IMG_H - 1);
  localparam logic [15:0] c_W_MAX   = 16'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [15:0]               r_row;
  logic [15:0]               r_col;
  logic [3:0]                r_tap;   // tap index presented on the RAM port this cycle
  logic                      r_pad;   // that tap lies outside the image (zero-pad mode)
  logic [RD_LAT-1:0]         r_pv;
  logic [RD_LAT-1:0]         r_pp;
  logic [RD_LAT-1:0][3:0]    r_pi;
  logic [0:8][PIX_W-1:0]     r_taps;  // element 0 lands in the MSBs of win_data

  logic [15:0]        w_nrow, w_ncol, w_cr, w_cc, w_rcl, w_ccl;
  logic               w_last, w_oob, w_pad, w_mem_en;
  logic [3:0]         w_ti;
  logic signed [16:0] w_dr, w_dc, w_tr, w_tc;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_cap, w_cap_pad;
  logic [3:0]         w_cap_idx;

  assign win_row  = r_row;
  assign win_col  = r_col;
  assign win_data = r_taps;

  assign w_last = (r_row == c_R_LAST) && (r_col == c_C_LAST);
  assign w_ncol = (r_col == c_C_LAST) ? c_C_FIRST : r_col + 16'd1;
  assign w_nrow = (r_col == c_C_LAST) ? r_row + 16'd1 : r_row;

  // The tap issued at the coming edge: tap 0 of the first/next centre when a
  // window starts, otherwise the following tap of the current centre.
  always_comb begin
    w_cr = r_row;
    w_cc = r_col;
    w_ti = r_tap + 4'd1;
    if (r_state == S_IDLE) begin
      w_cr = c_R_FIRST;
      w_cc = c_C_FIRST;
      w_ti = 4'd0;
    end else if (r_state == S_OUT) begin
      w_cr = w_nrow;
      w_cc = w_ncol;
      w_ti = 4'd0;
    end
  end

  always_comb begin
    case (w_ti)
      4'd0, 4'd1, 4'd2: w_dr = -17'sd1;
      4'd3, 4'd4, 4'd5: w_dr = 17'sd0;
      default:          w_dr = 17'sd1;
    endcase
    case (w_ti)
      4'd0, 4'd3, 4'd6: w_dc = -17'sd1;
      4'd1, 4'd4, 4'd7: w_dc = 17'sd0;
      default:          w_dc = 17'sd1;
    endcase
  end

  // One extra signed bit lets -1 and IMG_W/IMG_H be represented before clamping.
  assign w_tr = $signed({1'b0, w_cr}) + w_dr;
  assign w_tc = $signed({1'b0, w_cc}) + w_dc;

  always_comb begin
    w_oob = (w_tr < 17'sd0) || (w_tr > $signed({1'b0, c_H_MAX})) ||
            (w_tc < 17'sd0) || (w_tc > $signed({1'b0, c_W_MAX}));
    if (w_tr < 17'sd0)                          w_rcl = 16'd0;
    else if (w_tr > $signed({1'b0, c_H_MAX}))   w_rcl = c_H_MAX;
    else                                        w_rcl = w_tr[15:0];
    if (w_tc < 17'sd0)                          w_ccl = 16'd0;
    else if (w_tc > $signed({1'b0, c_W_MAX}))   w_ccl = c_W_MAX;
    else                                        w_ccl = w_tc[15:0];
  end

  // Clamped coordinates always form the address; in zero-pad mode the read
  // itself is suppressed for out-of-range taps, so the address is don't-care.
  assign w_pad    = (BORDER == 1) && w_oob;
  assign w_mem_en = !w_pad;
  assign w_addr   = ADDR_W'(w_rcl) * ADDR_W'(IMG_W) + ADDR_W'(w_ccl);

  assign w_cap     = r_pv[RD_LAT-1];
  assign w_cap_idx = r_pi[RD_LAT-1];
  assign w_cap_pad = r_pp[RD_LAT-1];

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_tap     <= '0;
      r_pad     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      win_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FETCH;
            busy     <= 1'b1;
            r_row    <= w_cr;
            r_col    <= w_cc;
            r_tap    <= 4'd0;
            mem_en   <= w_mem_en;
            mem_addr <= w_addr;
            r_pad    <= w_pad;
          end
        end
        S_FETCH: begin
          if (r_tap == 4'd8) begin
            r_state <= S_WAIT;
            mem_en  <= 1'b0;
            r_pad   <= 1'b0;
          end else begin
            r_tap    <= r_tap + 4'd1;
            mem_en   <= w_mem_en;
            mem_addr <= w_addr;
            r_pad    <= w_pad;
          end
        end
        S_WAIT: begin
          if (w_cap && (w_cap_idx == 4'd8)) begin
            r_state   <= S_OUT;
            win_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state  <= S_FETCH;
              r_row    <= w_cr;
              r_col    <= w_cc;
              r_tap    <= 4'd0;
              mem_en   <= w_mem_en;
              mem_addr <= w_addr;
              r_pad    <= w_pad;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tap index / pad flag travel alongside the RAM read so each returning word
  // is steered into the right tap register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv   <= '0;
      r_pp   <= '0;
      r_pi   <= '0;
      r_taps <= '0;
    end else begin
      r_pv[0] <= (r_state == S_FETCH);
      r_pi[0] <= r_tap;
      r_pp[0] <= r_pad;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pi[i] <= r_pi[i-1];
        r_pp[i] <= r_pp[i-1];
      end
      if (w_cap) begin
        r_taps[w_cap_idx] <= w_cap_pad ? '0 : mem_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_window_fetcher                                            |
// | Description : Directed bench for window_fetcher on a 4x4 image whose       |
// |               pixel value equals its raster address. Four instances cover  |
// |               border modes 0/1/2 and a 3-cycle RAM read latency.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_window_fetcher;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v, ready_v, busy_v, done_v, en_v, valid_v;
  logic [3:0]  addr_v  [4];
  logic [7:0]  dout_v  [4];
  logic [71:0] data_v  [4];
  logic [15:0] row_v   [4];
  logic [15:0] col_v   [4];
  logic [7:0]  ram_p   [4][3];

  logic [1:0]  sel;
  logic        m_busy, m_done, m_en, m_valid;
  logic [3:0]  m_addr;
  logic [71:0] m_data;
  logic [15:0] m_row, m_col;

  int          n_checks, n_fail;
  logic [71:0] win_d [16];
  int          win_r [16], win_c [16], win_t [16];
  int          nwin, ndone, done_cyc, stall_bad, busy_tail;
  logic        busy_at_done, busy_c0, frame_ok;
  logic [8:0]  en_hist;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: interior, lat 1 / 1: zero pad / 2: interior, lat 3 / 3: clamp
  window_fetcher #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .RD_LAT(1), .BORDER(0)) u_b0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .mem_en(en_v[0]), .mem_addr(addr_v[0]), .mem_dout(dout_v[0]), .win_data(data_v[0]),
    .win_valid(valid_v[0]), .win_ready(ready_v[0]), .win_row(row_v[0]), .win_col(col_v[0]));
  window_fetcher #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .RD_LAT(1), .BORDER(1)) u_b1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .mem_en(en_v[1]), .mem_addr(addr_v[1]), .mem_dout(dout_v[1]), .win_data(data_v[1]),
    .win_valid(valid_v[1]), .win_ready(ready_v[1]), .win_row(row_v[1]), .win_col(col_v[1]));
  window_fetcher #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .RD_LAT(3), .BORDER(0)) u_l3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .mem_en(en_v[2]), .mem_addr(addr_v[2]), .mem_dout(dout_v[2]), .win_data(data_v[2]),
    .win_valid(valid_v[2]), .win_ready(ready_v[2]), .win_row(row_v[2]), .win_col(col_v[2]));
  window_fetcher #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .RD_LAT(1), .BORDER(2)) u_b2 (
    .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .mem_en(en_v[3]), .mem_addr(addr_v[3]), .mem_dout(dout_v[3]), .win_data(data_v[3]),
    .win_valid(valid_v[3]), .win_ready(ready_v[3]), .win_row(row_v[3]), .win_col(col_v[3]));

  // RAM model: pixel = address; a disabled read returns a poison value.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ram_p[i][0] <= en_v[i] ? {4'h0, addr_v[i]} : 8'hEE;
      ram_p[i][1] <= ram_p[i][0];
      ram_p[i][2] <= ram_p[i][1];
    end
  end
  assign dout_v[0] = ram_p[0][0];
  assign dout_v[1] = ram_p[1][0];
  assign dout_v[2] = ram_p[2][2];
  assign dout_v[3] = ram_p[3][0];

  always_comb begin
    m_busy  = busy_v[sel];
    m_done  = done_v[sel];
    m_en    = en_v[sel];
    m_valid = valid_v[sel];
    m_addr  = addr_v[sel];
    m_data  = data_v[sel];
    m_row   = row_v[sel];
    m_col   = col_v[sel];
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference window for a 4x4 image with pixel = r*4 + c.
  function automatic logic [71:0] model(input int border, input int r, input int c);
    logic [71:0] v;
    int tr, tc;
    bit oob;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      tr  = r + k / 3 - 1;
      tc  = c + k % 3 - 1;
      oob = (tr < 0) || (tr > 3) || (tc < 0) || (tc > 3);
      if (tr < 0) tr = 0;
      if (tr > 3) tr = 3;
      if (tc < 0) tc = 0;
      if (tc > 3) tc = 3;
      v = {v[63:0], (oob && border == 1) ? 8'h00 : 8'(tr * 4 + tc)};
    end
    return v;
  endfunction

  // Runs one frame on instance s. stall_win: window index held off for 20
  // cycles (-1 = none). sad: pulse start in the done cycle.
  task automatic run_frame(input int s, input int stall_win, input bit sad);
    int stall_cnt, tail, cyc;
    logic [71:0] sd;
    logic [31:0] sp;
    nwin = 0; ndone = 0; done_cyc = -1; stall_bad = 0; busy_tail = 0;
    stall_cnt = 0; tail = 0; frame_ok = 1'b0; en_hist = '0; busy_at_done = 1'b1;
    sd = '0; sp = '0;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = '0; win_r[i] = -1; win_c[i] = -1; win_t[i] = -1;
    end
    @(negedge clk);
    sel = 2'(s);
    ready_v[s] = 1'b1;
    start_v[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[s] = 1'b0;
    busy_c0 = m_busy;
    for (cyc = 0; cyc < 600 && !frame_ok; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start_v[s] = 1'b0;
      if (cyc < 9) en_hist[8-cyc] = m_en;
      if (m_valid) begin
        if (nwin == stall_win && stall_cnt < 20) begin
          if (stall_cnt == 0) begin
            sd = m_data; sp = {m_row, m_col};
          end else if (m_data !== sd || {m_row, m_col} !== sp) begin
            stall_bad++;
          end
          if (m_en) stall_bad++;
          stall_cnt++;
          ready_v[s] = 1'b0;
        end else begin
          if (nwin == stall_win && (m_data !== sd || {m_row, m_col} !== sp)) stall_bad++;
          if (nwin < 16) begin
            win_d[nwin] = m_data; win_r[nwin] = int'(m_row);
            win_c[nwin] = int'(m_col); win_t[nwin] = cyc;
          end
          nwin++;
          ready_v[s] = 1'b1;
        end
      end
      if (m_done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = m_busy;
          if (sad) start_v[s] = 1'b1;
        end
      end else if (ndone > 0) begin
        busy_tail += int'(m_busy);
        tail++;
        if (tail > 3) frame_ok = 1'b1;
      end
    end
    start_v[s] = 1'b0;
    check_eq("frame completes", 72'(frame_ok), 72'(1));
  endtask

  task automatic check_frame(input string nm, input int border, input int nexp,
                             input int t_first, input int period);
    int er, ec;
    check_eq({nm, " window count"}, 72'(nwin), 72'(nexp));
    check_eq({nm, " done pulses"}, 72'(ndone), 72'(1));
    check_eq({nm, " first valid cycle"}, 72'(win_t[0]), 72'(t_first));
    check_eq({nm, " busy at done"}, 72'(busy_at_done), 72'(0));
    if (nwin > 0 && nwin <= 16)
      check_eq({nm, " done cycle"}, 72'(done_cyc), 72'(win_t[nwin-1] + 1));
    for (int i = 0; i < nexp; i++) begin
      er = (border == 0) ? 1 + i / 2 : i / 4;
      ec = (border == 0) ? 1 + i % 2 : i % 4;
      check_eq($sformatf("%s w%0d data", nm, i), win_d[i], model(border, er, ec));
      check_eq($sformatf("%s w%0d pos", nm, i), 72'({win_r[i], win_c[i]}), 72'({er, ec}));
      if (period > 0 && i > 0)
        check_eq($sformatf("%s w%0d period", nm, i), 72'(win_t[i] - win_t[i-1]), 72'(period));
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start_v = '0; ready_v = '1; sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check_eq("reset ctl", 72'({m_busy, m_done, m_en, m_valid, m_addr}), 72'(0));
      check_eq("reset data", m_data, 72'(0));
      check_eq("reset pos", 72'({m_row, m_col}), 72'(0));
    end

    // Interior windows, RD_LAT 1; a start in the done cycle must be ignored.
    run_frame(0, -1, 1'b1);
    check_frame("b0", 0, 4, 10, 11);
    check_eq("b0 w0 hand", win_d[0], 72'h00010204050608090A);
    check_eq("b0 busy cycle0", 72'(busy_c0), 72'(1));
    check_eq("b0 start at done ignored", 72'(busy_tail), 72'(0));

    // Zero-padded full frame.
    run_frame(1, -1, 1'b0);
    check_frame("b1", 1, 16, 10, 11);
    check_eq("b1 w0 hand", win_d[0], 72'h000000000001000405);
    check_eq("b1 w15 hand", win_d[15], 72'h0A0B000E0F00000000);
    check_eq("b1 w0 mem_en", 72'(en_hist), 72'(9'b000011011));

    // Clamped full frame.
    run_frame(3, -1, 1'b0);
    check_frame("b2", 2, 16, 10, 11);
    check_eq("b2 w0 hand", win_d[0], 72'h000001000001040405);
    check_eq("b2 w15 hand", win_d[15], 72'h0A0B0B0E0F0F0E0F0F);

    // Three-cycle RAM latency.
    run_frame(2, -1, 1'b0);
    check_frame("lat3", 0, 4, 12, 13);

    // Backpressure on the second window.
    run_frame(0, 1, 1'b0);
    check_frame("stall", 0, 4, 10, 0);
    check_eq("stall stable", 72'(stall_bad), 72'(0));
    check_eq("stall w1 accept cycle", 72'(win_t[1]), 72'(41));
    check_eq("stall w2 gap", 72'(win_t[2] - win_t[1]), 72'(11));

    // Reset during the fetch of window 3, then restart.
    @(negedge clk);
    sel = 2'd0; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (26) @(negedge clk);
    check_eq("pre-rst fetch", 72'({m_en, m_addr}), 72'({1'b1, 4'd9}));
    check_eq("pre-rst pos", 72'({m_row, m_col}), 72'({16'd2, 16'd1}));
    rst = 1'b0;
    #1;
    check_eq("mid rst ctl", 72'({m_busy, m_done, m_en, m_valid, m_addr}), 72'(0));
    check_eq("mid rst data", m_data, 72'(0));
    check_eq("mid rst pos", 72'({m_row, m_col}), 72'(0));
    @(negedge clk);
    rst = 1'b1;
    run_frame(0, -1, 1'b0);
    check_frame("rerun", 0, 4, 10, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_fetcher.md
# window_fetcher

Parametrised 3x3 neighbourhood fetcher for the image-filter datapath. It reads pixels from an external single-port block RAM that holds an IMG_W x IMG_H image in raster order, and presents one 3x3 window per transfer on a valid/ready output. Compared with the previous fixed 100x100 reader, it adds configurable image size, pixel width, RAM read latency and border mode, plus a start/done handshake and output backpressure. It sits between the image storage RAM and the filter core.

## Interface
- IMG_W, 100: image width in pixels, ≥ 3
- IMG_H, 100: image height in pixels, ≥ 3
- PIX_W, 8: pixel width in bits
- ADDR_W, 14: RAM address width; must be ≥ ceil(log2(IMG_W*IMG_H))
- RD_LAT, 1: RAM read latency in cycles, 1..4
- BORDER, 0: border mode. 0 = interior windows only. 1 = full frame, out-of-range taps read as 0. 2 = full frame, out-of-range taps use the clamped edge pixel.

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window is accepted
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_dout  in  PIX_W  RAM read data
- win_data  out  9*PIX_W  window {t0..t8}, with t0 in the MSBs
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts the window
- win_row  out  16  centre row of the current window
- win_col  out  16  centre column of the current window

## Operation
- Tap order: t0..t8 = (r-1,c-1), (r-1,c), (r-1,c+1), (r,c-1), (r,c), (r,c+1), (r+1,c-1), (r+1,c), (r+1,c+1).
- Centre scan order is raster, with the column advancing fastest.
  - BORDER 0: r from 1 to IMG_H-2, c from 1 to IMG_W-2. Total (IMG_W-2)(IMG_H-2) windows.
  - BORDER 1 or 2: r from 0 to IMG_H-1, c from 0 to IMG_W-1. Total IMG_W*IMG_H windows.
- Coordinate arithmetic uses one extra signed bit so that -1 and IMG_W/IMG_H are representable. Address = row*IMG_W + col, computed in ADDR_W bits.
- Out-of-range taps:
  - BORDER 2: row and column are clamped to [0, dim-1], and the tap is read normally.
  - BORDER 1: mem_en is low for the tap, and a pad flag travels down a RD_LAT-deep pipeline together with the tap index. The captured value is forced to 0.
- A tap index and pad flag pipeline RD_LAT deep routes each returning mem_dout into its tap register.
- FSM states:
  - IDLE: start=1 moves to FETCH, loads the first centre and sets busy.
  - FETCH: 9 cycles, one tap issued per cycle (mem_en=1 except BORDER 1 pad taps), then move to WAIT.
  - WAIT: RD_LAT cycles, until the last tap is captured, then move to OUT.
  - OUT: win_valid=1. When win_ready=1, advance the centre. Go to FETCH, or to DONE if this was the last window.
  - DONE: done=1 for one cycle, busy drops, then IDLE.
- Behaviour in OUT: win_data, win_row and win_col are held stable while win_valid=1 and win_ready=0. A fetch never overlaps an unaccepted window.
- start is ignored outside IDLE.
- Reset, including mid-frame: all outputs go to their reset values, in-flight reads are discarded, and the FSM returns to IDLE.

## Timing
- Reset values: busy, done, mem_en and win_valid are 0. mem_addr, win_data, win_row and win_col are 0.
- mem_dout for an address presented in cycle n is valid in cycle n+RD_LAT and is captured at the end of that cycle.
- Latency: with start sampled at edge E0, tap k is presented in cycle k (k = 0..8, cycle 0 follows E0). win_valid first rises in cycle 9+RD_LAT.
- Throughput: with win_ready held at 1, the window period is 10+RD_LAT cycles (11 for RD_LAT=1).
- done rises in the cycle after the accepting edge of the final window. busy falls in the same cycle that done pulses.
- A start pulse that coincides with done is ignored.

## Test plan
- Common setup: IMG_W = IMG_H = 4, PIX_W = 8, RAM model with pixel = row*4 + col.
- BORDER=0, RD_LAT=1, win_ready=1 -> exactly 4 windows. The first has win_row=1, win_col=1, win_data=0x000102040506080 90A. The first win_valid rises in cycle 10, the windows arrive 11 cycles apart, and done pulses once.
- BORDER=1 -> 16 windows. Window (0,0) = 0x000000000001000405, and mem_en is low on its 5 pad taps. Window (3,3) = 0x0A0B000E0F0000 0000.
- BORDER=2 -> window (0,0) = 0x000001000001040405.
- RD_LAT=3 -> data is the same as for RD_LAT=1. The first win_valid rises in cycle 12, and the period is 13 cycles.
- win_ready held at 0 for 20 cycles on the second window -> win_valid stays 1, win_data/win_row/win_col stay constant, and mem_en stays 0. No window is lost or duplicated.
- rst pulled low during FETCH of window 3, then start reissued -> all outputs return to 0 immediately. The new frame begins at centre (1,1) with the correct data.
